sensor_ctrl: RTL and testbench

Upstream stage of the sensor wrapper. Handshakes with the external sensor and captures DEPTH 32-bit samples into an internal buffer. Raises an interrupt when the buffer is full. Exposes a random-access read port, which the wrapper drives with its ADDR_SIZE-bit word address, plus the enable and clear controls the wrapper decodes from SCTRL_ENB_ADDR and SCTRL_CLEAR_ADDR.

---
 rtl/sensor_ctrl_pkg.sv | 22 ++
 rtl/sensor_buffer.sv | 30 +++
 rtl/sensor_ctrl.sv | 116 +++++++++++
 tb/tb_sensor_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_ctrl_pkg.sv
// Shared definitions for the sensor capture block: buffer geometry, the
// one-hot state encoding and the idle data pattern.
package sensor_ctrl_pkg;

    localparam int ADDR_SIZE = 6;
    localparam int DATA_SIZE = 32;
    localparam int DEPTH     = 64;

    // Bit positions of the one-hot state vector
    localparam int IDLE_BIT    = 0;
    localparam int COLLECT_BIT = 1;
    localparam int FULL_BIT    = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'b001 << IDLE_BIT,
        COLLECT = 3'b001 << COLLECT_BIT,
        FULL    = 3'b001 << FULL_BIT
    } sensor_ctrl_state_t;

    localparam logic [DATA_SIZE-1:0] EMPTY_DATA = {DATA_SIZE{1'b0}};

endpackage : sensor_ctrl_pkg

// File: rtl/sensor_buffer.sv
// Sample store: register array with one synchronous write port and one
// combinational read port. Contents are deliberately not reset so that a
// captured frame survives a controller clear or reset.
module sensor_buffer
    import sensor_ctrl_pkg::*;
#(
    parameter int AW    = sensor_ctrl_pkg::ADDR_SIZE,
    parameter int DW    = sensor_ctrl_pkg::DATA_SIZE,
    parameter int NWORD = sensor_ctrl_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [NWORD];

    // Store the accepted sample; a same-cycle read still sees the old word
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : sensor_buffer

// File: rtl/sensor_ctrl.sv
// Sensor capture controller: handshakes with the sensor, fills the sample
// buffer in order, raises a level interrupt once the buffer is full, and
// offers a random-access read port to the wrapper.
module sensor_ctrl #(
    parameter int ADDR_SIZE = sensor_ctrl_pkg::ADDR_SIZE,
    parameter int DATA_SIZE = sensor_ctrl_pkg::DATA_SIZE,
    parameter int DEPTH     = sensor_ctrl_pkg::DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sctrl_en,
    input  logic                 sctrl_clear,
    input  logic [ADDR_SIZE-1:0] sctrl_addr,
    output logic [DATA_SIZE-1:0] sctrl_out,
    output logic                 sctrl_interrupt,
    input  logic                 sensor_ready,
    input  logic [DATA_SIZE-1:0] sensor_out,
    output logic                 sensor_en
);

    import sensor_ctrl_pkg::*;

    localparam logic [ADDR_SIZE:0] COUNT_ZERO = {(ADDR_SIZE+1){1'b0}};
    localparam logic [ADDR_SIZE:0] COUNT_ONE  = {{ADDR_SIZE{1'b0}}, 1'b1};
    localparam logic [ADDR_SIZE:0] COUNT_LAST = (ADDR_SIZE+1)'(DEPTH - 1);

    sensor_ctrl_state_t   state_q;
    logic [ADDR_SIZE:0]   count_q;
    logic [ADDR_SIZE:0]   count_d;
    logic                 irq_q;
    logic                 sensor_en_s;
    logic                 accept_s;
    logic                 last_s;

    // Request samples only while collecting and enabled; a clear overrides
    always_comb begin
        sensor_en_s = 1'b0;
        if (sctrl_clear) begin
            sensor_en_s = 1'b0;
        end else if (state_q == COLLECT) begin
            sensor_en_s = sctrl_en;
        end else begin
            sensor_en_s = 1'b0;
        end
    end

    assign accept_s = sensor_en_s & sensor_ready;
    assign last_s   = accept_s & (count_q == COUNT_LAST);
    assign count_d  = count_q + COUNT_ONE;

    // Capture FSM, sample counter and full interrupt; clear beats any sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= COUNT_ZERO;
            irq_q   <= 1'b0;
        end else if (sctrl_clear) begin
            state_q <= IDLE;
            count_q <= COUNT_ZERO;
            irq_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sctrl_en) begin
                        state_q <= COLLECT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                COLLECT: begin
                    if (accept_s) begin
                        count_q <= count_d;
                    end else begin
                        count_q <= count_q;
                    end
                    if (last_s) begin
                        state_q <= FULL;
                        irq_q   <= 1'b1;
                    end else if (!sctrl_en) begin
                        // Pause keeps count so collection resumes in place
                        state_q <= IDLE;
                    end else begin
                        state_q <= COLLECT;
                    end
                end
                FULL: begin
                    state_q <= FULL;
                    irq_q   <= 1'b1;
                end
                default: begin
                    // Illegal encoding: fall back to a clean empty state
                    state_q <= IDLE;
                    count_q <= COUNT_ZERO;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign sensor_en       = sensor_en_s;
    assign sctrl_interrupt = irq_q;

    sensor_buffer #(
        .AW    (ADDR_SIZE),
        .DW    (DATA_SIZE),
        .NWORD (DEPTH)
    ) u_buffer (
        .clk     (clk),
        .we_i    (accept_s),
        .waddr_i (count_q[ADDR_SIZE-1:0]),
        .wdata_i (sensor_out),
        .raddr_i (sctrl_addr),
        .rdata_o (sctrl_out)
    );

endmodule : sensor_ctrl

// File: tb/tb_sensor_ctrl.sv
// Self-checking bench for sensor_ctrl: directed sequences, a vector table for
// clear priority and read-during-write, and randomized traffic against a
// frame-level reference model (sample count, running flag, stored words).
module tb_sensor_ctrl;

    localparam int NW = 64;

    logic        clk;
    logic        rst_n;
    logic        sctrl_en;
    logic        sctrl_clear;
    logic [5:0]  sctrl_addr;
    logic [31:0] sctrl_out;
    logic        sctrl_interrupt;
    logic        sensor_ready;
    logic [31:0] sensor_out;
    logic        sensor_en;

    sensor_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sctrl_en        (sctrl_en),
        .sctrl_clear     (sctrl_clear),
        .sctrl_addr      (sctrl_addr),
        .sctrl_out       (sctrl_out),
        .sctrl_interrupt (sctrl_interrupt),
        .sensor_ready    (sensor_ready),
        .sensor_out      (sensor_out),
        .sensor_en       (sensor_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: how many samples are held, whether collection is
    // running, and what each buffer word should contain.
    int          m_count = 0;
    bit          m_running = 1'b0;
    logic [31:0] m_mem [NW];
    bit          m_valid [NW];

    typedef struct {
        logic        en;
        logic        clr;
        logic        rdy;
        logic [31:0] data;
        logic [5:0]  addr;
        logic        exp_sen;
        logic        exp_irq;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_count   = 0;
        m_running = 1'b0;
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle,
    // advance the model at the edge. Entered and left at posedge+1.
    task automatic cycle(input logic en, input logic clr, input logic rdy,
                         input logic [31:0] data, input logic [5:0] addr,
                         output logic o_sen, output logic o_irq, output logic [31:0] o_out);
        bit exp_sen;
        sctrl_en     = en;
        sctrl_clear  = clr;
        sensor_ready = rdy;
        sensor_out   = data;
        sctrl_addr   = addr;
        #2;
        o_sen = sensor_en;
        o_irq = sctrl_interrupt;
        o_out = sctrl_out;
        exp_sen = m_running && en && !clr && (m_count < NW);
        check("sensor_en", 32'(o_sen), 32'(exp_sen));
        check("interrupt", 32'(o_irq), 32'(m_count == NW));
        if (m_valid[addr]) check("read_data", o_out, m_mem[addr]);
        @(posedge clk);
        if (clr) begin
            m_count   = 0;
            m_running = 1'b0;
        end else if (m_count < NW) begin
            if (exp_sen && rdy) begin
                m_mem[m_count]   = data;
                m_valid[m_count] = 1'b1;
                m_count++;
            end
            m_running = en;
        end
        #1;
    endtask

    task automatic step(input logic en, input logic clr, input logic rdy,
                        input logic [31:0] data, input logic [5:0] addr);
        logic s, i;
        logic [31:0] o;
        cycle(en, clr, rdy, data, addr, s, i, o);
    endtask

    task automatic peek(input logic [5:0] a, input logic [31:0] exp, input string nm);
        sctrl_addr = a;
        #1;
        check(nm, sctrl_out, exp);
    endtask

    // Keep sampling with data base+index until the model holds target samples
    task automatic collect_until(input int target, input logic [31:0] base);
        int budget = 0;
        while (m_count < target && budget < 300) begin
            step(1'b1, 1'b0, 1'b1, base + 32'(m_count), 6'($urandom_range(0, 63)));
            budget++;
        end
        if (budget >= 300) begin
            errors++;
            checks++;
            $display("FAIL collect_timeout: got count %0d expected %0d", m_count, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic s, i;
        logic [31:0] o;

        rst_n = 1'b0; sctrl_en = 1'b0; sctrl_clear = 1'b0; sctrl_addr = 6'd0;
        sensor_ready = 1'b0; sensor_out = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_sensor_en", 32'(sensor_en), 32'd0);
        check("reset_interrupt", 32'(sctrl_interrupt), 32'd0);
        rst_n = 1'b1;
        model_reset();

        // Partial collection, then an asynchronous reset mid-cycle
        step(1'b1, 1'b0, 1'b0, 32'd0, 6'd0);
        repeat (3) step(1'b1, 1'b0, 1'b1, $urandom, 6'd0);
        sctrl_en = 1'b1;
        #2;
        check("pre_async_sensor_en", 32'(sensor_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_sensor_en", 32'(sensor_en), 32'd0);
        check("async_reset_interrupt", 32'(sctrl_interrupt), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full frame: one IDLE cycle, then 64 back-to-back samples
        step(1'b1, 1'b0, 1'b0, 32'd0, 6'd0);
        for (int k = 0; k < NW; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 32'h1000 + 32'(k), 6'd0, s, i, o);
            check("irq_low_while_filling", 32'(i), 32'd0);
        end
        check("full_interrupt", 32'(sctrl_interrupt), 32'd1);
        check("full_sensor_en", 32'(sensor_en), 32'd0);
        peek(6'd0,  32'h1000, "full_addr0");
        peek(6'd31, 32'h101F, "full_addr31");
        peek(6'd63, 32'h103F, "full_addr63");

        // Ready pulse while full is ignored
        step(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 6'd0);
        peek(6'd0, 32'h1000, "frozen_addr0");
        check("frozen_interrupt", 32'(sctrl_interrupt), 32'd1);

        // Pause and resume: 10 samples, 5 disabled cycles, 54 more
        step(1'b0, 1'b1, 1'b0, 32'd0, 6'd0);
        check("clear_interrupt", 32'(sctrl_interrupt), 32'd0);
        collect_until(10, 32'h2000);
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'd0, 6'd10);
        collect_until(NW, 32'h2000);
        check("resume_interrupt", 32'(sctrl_interrupt), 32'd1);
        peek(6'd10, 32'h200A, "resume_addr10");
        peek(6'd9,  32'h2009, "resume_addr9");

        // Clear collides with a sample at count 5, then read-during-write
        step(1'b0, 1'b1, 1'b0, 32'd0, 6'd0);
        collect_until(5, 32'h3000);
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'hAAAA_0005, 6'd5, 1'b0, 1'b0, 32'h2005};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0,         6'd5, 1'b0, 1'b0, 32'h2005};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0077, 6'd0, 1'b1, 1'b0, 32'h3000};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0,         6'd0, 1'b1, 1'b0, 32'h0000_0077};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_0011, 6'd1, 1'b1, 1'b0, 32'h3001};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_0022, 6'd2, 1'b1, 1'b0, 32'h3002};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_0033, 6'd3, 1'b1, 1'b0, 32'h3003};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h0,         6'd3, 1'b1, 1'b0, 32'h0000_0033};
        for (int v = 0; v < 8; v++) begin
            cycle(vecs[v].en, vecs[v].clr, vecs[v].rdy, vecs[v].data, vecs[v].addr, s, i, o);
            check($sformatf("vec%0d_sensor_en", v), 32'(s), 32'(vecs[v].exp_sen));
            check($sformatf("vec%0d_interrupt", v), 32'(i), 32'(vecs[v].exp_irq));
            check($sformatf("vec%0d_read", v), o, vecs[v].exp_out);
        end

        // Randomized traffic; clears are confined to a window of each phase
        // so the buffer regularly reaches full in between
        for (int n = 0; n < 3000; n++) begin
            logic en_r, clr_r;
            en_r  = ($urandom_range(0, 7) != 0);
            clr_r = ((n % 400) >= 360) && ($urandom_range(0, 9) == 0);
            step(en_r, clr_r, 1'($urandom_range(0, 1)), $urandom, 6'($urandom_range(0, 63)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sensor_ctrl
